// File: rtl/payload_streamer.sv
// -----------------------------------------------------------------------------
// payload_streamer
//
// Double-buffered, multi-channel stimulus streamer. The load port fills one of
// two banks with beats of CHANNELS x ITEM_WIDTH items. Meanwhile the other bank
// drains through a registered valid/ready output stage at one beat per clock.
// Banks are drained strictly in the order they were filled. Bursts shorter than
// DEPTH are closed with ld_last_i.
//
// Parameters
//   CHANNELS    items per beat (ch0 = A operand, ch1 = B operand)
//   ITEM_WIDTH  bits per item
//   DEPTH       beats per bank (>= 2)
//   PTR_W       derived count width, $clog2(DEPTH+1)
//
// Ports
//   clk_i        in   single clock, posedge
//   reset_ni     in   asynchronous active-low reset
//   ld_valid_i   in   load beat valid
//   ld_ready_o   out  load beat accepted when valid & ready (registered)
//   ld_data_i    in   channel k at [k*ITEM_WIDTH +: ITEM_WIDTH]
//   ld_last_i    in   closes the current fill bank after this beat
//   out_valid_o  out  output beat valid
//   out_ready_i  in   DUT-side accept
//   out_data_o   out  same channel packing as ld_data_i
//   out_last_o   out  final beat of the bank being drained
//   done_o       out  1-cycle pulse after a bank has fully drained
//   busy_o       out  any bank not EMPTY
//   beat_cnt_o   out  (STREAMER_STATS_EN only) saturating count of accepted
//                     output beats since reset
//
// Optional feature macro: STREAMER_STATS_EN
// -----------------------------------------------------------------------------
module payload_streamer #(
  parameter  int CHANNELS   = 2,
  parameter  int ITEM_WIDTH = 8,
  parameter  int DEPTH      = 1000,
  localparam int PTR_W      = $clog2(DEPTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic                           ld_valid_i,
  output logic                           ld_ready_o,
  input  logic [CHANNELS*ITEM_WIDTH-1:0] ld_data_i,
  input  logic                           ld_last_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [CHANNELS*ITEM_WIDTH-1:0] out_data_o,
  output logic                           out_last_o,
  output logic                           done_o,
  output logic                           busy_o
`ifdef STREAMER_STATS_EN
  ,
  output logic [31:0]                    beat_cnt_o
`endif
);

  localparam int DW    = CHANNELS * ITEM_WIDTH;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  // Per-bank bookkeeping
  bank_state_e      state_q [2];
  bank_state_e      state_d [2];
  logic [PTR_W-1:0] count_q [2];
  logic [PTR_W-1:0] count_d [2];
  logic [1:0]       ready_q;     // bank has been FULL for at least one cycle

  // Fill side
  logic             fill_sel_q, fill_sel_d;
  logic [IDX_W-1:0] fill_ptr_q, fill_ptr_d;
  logic             ld_ready_q, ld_ready_d;

  // Drain side: fetch_* walks the bank feeding the output register, drain_sel
  // names the bank whose beat currently sits in the output register.
  logic             drain_sel_q, drain_sel_d;
  logic             fetch_sel_q, fetch_sel_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             fetch_active_q, fetch_active_d;

  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;

  logic [DW-1:0]    mem_q [2][DEPTH];

  logic ld_fire, ld_close, out_fire, slot_free, fetch_en, fetch_last;

  assign ld_fire    = ld_valid_i & ld_ready_q;
  assign ld_close   = ld_last_i | (fill_ptr_q == IDX_W'(DEPTH - 1));
  assign out_fire   = out_valid_q & out_ready_i;
  // The output register can take a new beat when empty or being emptied now.
  assign slot_free  = ~out_valid_q | out_ready_i;
  // A bank starts draining only once it has been FULL for a cycle; after its
  // first fetch the remaining beats follow without re-qualification.
  assign fetch_en   = slot_free &
                      (fetch_active_q |
                       ((state_q[fetch_sel_q] == BANK_FULL) & ready_q[fetch_sel_q]));
  assign fetch_last = (PTR_W'(rd_ptr_q) == (count_q[fetch_sel_q] - PTR_W'(1)));

  // NOTE: every combinational output gets a default at the top of the block,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    fill_sel_d     = fill_sel_q;
    fill_ptr_d     = fill_ptr_q;
    drain_sel_d    = drain_sel_q;
    fetch_sel_d    = fetch_sel_q;
    rd_ptr_d       = rd_ptr_q;
    fetch_active_d = fetch_active_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_last_d     = out_last_q;
    done_d         = 1'b0;

    // Fill: only ever touches an EMPTY/FILLING bank.
    if (ld_fire) begin
      if (ld_close) begin
        state_d[fill_sel_q] = BANK_FULL;
        count_d[fill_sel_q] = PTR_W'(fill_ptr_q) + PTR_W'(1);
        fill_sel_d          = ~fill_sel_q;
        fill_ptr_d          = '0;
      end else begin
        state_d[fill_sel_q] = BANK_FILLING;
        fill_ptr_d          = fill_ptr_q + IDX_W'(1);
      end
    end

    // Acceptance: only ever touches the FULL/DRAINING bank in the output reg.
    if (out_fire) begin
      if (out_last_q) begin
        state_d[drain_sel_q] = BANK_EMPTY;
        drain_sel_d          = ~drain_sel_q;
        done_d               = 1'b1;
      end else begin
        state_d[drain_sel_q] = BANK_DRAINING;
      end
    end

    // Output register refill; holds everything while stalled.
    if (slot_free) begin
      out_valid_d = fetch_en;
      out_last_d  = 1'b0;
      if (fetch_en) begin
        out_data_d = mem_q[fetch_sel_q][rd_ptr_q];
        out_last_d = fetch_last;
        if (fetch_last) begin
          fetch_sel_d    = ~fetch_sel_q;
          rd_ptr_d       = '0;
          fetch_active_d = 1'b0;
        end else begin
          rd_ptr_d       = rd_ptr_q + IDX_W'(1);
          fetch_active_d = 1'b1;
        end
      end
    end

    // Ready reflects the bank that will be filled next, after this edge.
    ld_ready_d = (state_d[fill_sel_d] == BANK_EMPTY) ||
                 (state_d[fill_sel_d] == BANK_FILLING);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= BANK_EMPTY;
        count_q[b] <= '0;
      end
      ready_q        <= '0;
      fill_sel_q     <= 1'b0;
      fill_ptr_q     <= '0;
      ld_ready_q     <= 1'b1;
      drain_sel_q    <= 1'b0;
      fetch_sel_q    <= 1'b0;
      rd_ptr_q       <= '0;
      fetch_active_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_last_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      ready_q        <= {state_q[1] == BANK_FULL, state_q[0] == BANK_FULL};
      fill_sel_q     <= fill_sel_d;
      fill_ptr_q     <= fill_ptr_d;
      ld_ready_q     <= ld_ready_d;
      drain_sel_q    <= drain_sel_d;
      fetch_sel_q    <= fetch_sel_d;
      rd_ptr_q       <= rd_ptr_d;
      fetch_active_q <= fetch_active_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_last_q     <= out_last_d;
      done_q         <= done_d;
    end
  end

  // NOTE: bank storage is deliberately not reset; a beat is only ever read
  // after it has been written, and state/pointers carry all validity.
  always_ff @(posedge clk_i) begin
    if (ld_fire && reset_ni) begin
      mem_q[fill_sel_q][fill_ptr_q] <= ld_data_i;
    end
  end

`ifdef STREAMER_STATS_EN
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      beat_cnt_q <= '0;
    end else if (out_fire && (beat_cnt_q != 32'hFFFF_FFFF)) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
    end
  end

  assign beat_cnt_o = beat_cnt_q;
`endif

  assign ld_ready_o  = ld_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q[0] != BANK_EMPTY) | (state_q[1] != BANK_EMPTY);

endmodule

// File: tb/tb_payload_streamer.sv
// -----------------------------------------------------------------------------
// tb_payload_streamer
//
// Self-checking bench for payload_streamer with CHANNELS=2, ITEM_WIDTH=8,
// DEPTH=4. Every accepted load beat is pushed with its expected out_last into
// a scoreboard queue; a negedge monitor compares the front entry against the
// output whenever out_valid_o is high and pops it on a transfer. A table of
// bursts drives the free-flowing cases; hand-written sequences cover the reset
// and back-pressure corner cases.
// -----------------------------------------------------------------------------
module tb_payload_streamer;

  localparam int CH    = 2;
  localparam int IW    = 8;
  localparam int DEPTH = 4;
  localparam int DW    = CH * IW;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          ld_valid_i;
  logic          ld_ready_o;
  logic [DW-1:0] ld_data_i;
  logic          ld_last_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic          done_o;
  logic          busy_o;
`ifdef STREAMER_STATS_EN
  logic [31:0]   beat_cnt_o;
`endif

  payload_streamer #(
    .CHANNELS  (CH),
    .ITEM_WIDTH(IW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .ld_valid_i (ld_valid_i),
    .ld_ready_o (ld_ready_o),
    .ld_data_i  (ld_data_i),
    .ld_last_i  (ld_last_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
`ifdef STREAMER_STATS_EN
    ,
    .beat_cnt_o (beat_cnt_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } sb_t;

  typedef struct {
    int len;        // beats loaded
    bit last_end;   // drive ld_last_i on the final beat
    int exp_beats;  // output beats expected
    int exp_dones;  // done_o pulses expected
    int exp_span;   // cycles from first to last output transfer, inclusive
  } vec_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  bank_idx = 0;
  int  close_cyc, first_xfer_cyc, last_xfer_cyc;
  int  xfer_cnt, done_cnt;
  bit  mon_en = 1'b0;
  bit  done_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int base, input int i);
    logic [IW-1:0] a, b;
    a = IW'(base + 2 * i + 1);
    b = IW'(base + 2 * i + 2);
    return {b, a};
  endfunction

  task automatic clear_stats();
    close_cyc      = -1;
    first_xfer_cyc = -1;
    last_xfer_cyc  = -1;
    xfer_cnt       = 0;
    done_cnt       = 0;
  endtask

  // Drives one load beat starting at posedge+1; returns at posedge+1 after it
  // has been accepted (or after the wait budget is spent).
  task automatic send(input logic [DW-1:0] d, input logic last);
    int  w;
    logic exp_last;
    ld_valid_i = 1'b1;
    ld_data_i  = d;
    ld_last_i  = last;
    w = 0;
    @(negedge clk_i);
    while (!ld_ready_o && w < 200) begin
      @(negedge clk_i);
      w++;
    end
    if (!ld_ready_o) begin
      check("ld_ready_o wait budget", ld_ready_o, 1'b1);
    end else begin
      exp_last = last || (bank_idx == DEPTH - 1);
      sb_q.push_back('{d, exp_last});
      bank_idx = exp_last ? 0 : bank_idx + 1;
      @(posedge clk_i);
      #1;
      if (exp_last && close_cyc < 0) close_cyc = cyc;
    end
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int w = 0; w < 200 && sb_q.size() != 0; w++) @(negedge clk_i);
    check("scoreboard drained", sb_q.size(), 0);
    repeat (3) @(negedge clk_i);
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Output monitor / scoreboard consumer
  initial forever begin
    @(negedge clk_i);
    if (mon_en && reset_ni) begin
      check("done_o timing", done_o, done_exp);
      done_exp = 1'b0;
      if (done_o) done_cnt++;
      if (out_valid_o) begin
        if (sb_q.size() == 0) begin
          check("out_valid_o with empty scoreboard", out_valid_o, 1'b0);
        end else begin
          check("out_data_o", out_data_o, sb_q[0].data);
          check("out_last_o", out_last_o, sb_q[0].last);
          if (out_ready_i) begin
            if (sb_q[0].last) done_exp = 1'b1;
            if (xfer_cnt == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            xfer_cnt++;
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   sum_beats;

    vecs[0] = '{4,  1'b0, 4,  1, 4};   // auto-close at DEPTH
    vecs[1] = '{3,  1'b1, 3,  1, 3};   // short burst closed by ld_last_i
    vecs[2] = '{1,  1'b1, 1,  1, 1};   // single-beat bank
    vecs[3] = '{5,  1'b1, 5,  2, 5};   // full bank then 1-beat bank
    vecs[4] = '{8,  1'b0, 8,  2, 8};   // two full banks back-to-back
    vecs[5] = '{12, 1'b0, 12, 3, 14};  // third bank waits for a free bank

    reset_ni    = 1'b0;
    ld_valid_i  = 1'b0;
    ld_data_i   = '0;
    ld_last_i   = 1'b0;
    out_ready_i = 1'b0;
    clear_stats();

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    check("rst out_valid_o", out_valid_o, 1'b0);
    check("rst out_last_o", out_last_o, 1'b0);
    check("rst out_data_o", out_data_o, '0);
    check("rst done_o", done_o, 1'b0);
    check("rst busy_o", busy_o, 1'b0);
    reset_ni = 1'b1;
    @(negedge clk_i);
    check("post-rst ld_ready_o", ld_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    mon_en = 1'b1;

    // Test 1: reset in the middle of a drain
    for (int i = 0; i < 4; i++) send(beat(8'h90, i), 1'b0);
    for (int w = 0; w < 20 && !out_valid_o; w++) @(negedge clk_i);
    check("t1 out_valid_o before reset", out_valid_o, 1'b1);
    check("t1 busy_o before reset", busy_o, 1'b1);
    @(posedge clk_i);
    #1;
    mon_en     = 1'b0;
    reset_ni   = 1'b0;
    ld_valid_i = 1'b1;
    ld_data_i  = 16'hBEEF;
    ld_last_i  = 1'b1;
    #1;
    check("t1 out_valid_o in reset", out_valid_o, 1'b0);
    check("t1 done_o in reset", done_o, 1'b0);
    check("t1 busy_o in reset", busy_o, 1'b0);
    sb_q.delete();
    done_exp = 1'b0;
    bank_idx = 0;
    repeat (2) @(posedge clk_i);
    #1;
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
    reset_ni   = 1'b1;
    @(negedge clk_i);
    check("t1 ld_ready_o after release", ld_ready_o, 1'b1);
    check("t1 busy_o after release", busy_o, 1'b0);
    @(posedge clk_i);
    #1;
    mon_en      = 1'b1;
    out_ready_i = 1'b1;
    repeat (6) @(negedge clk_i);
    check("t1 no stale output", out_valid_o, 1'b0);
    @(posedge clk_i);
    #1;

    // Table-driven bursts with the output always ready
    sum_beats = 0;
    for (int e = 0; e < 6; e++) begin
      clear_stats();
      for (int i = 0; i < vecs[e].len; i++)
        send(beat(16 * e, i), vecs[e].last_end && (i == vecs[e].len - 1));
      wait_drain();
      sum_beats += vecs[e].exp_beats;
      check($sformatf("v%0d beats", e), xfer_cnt, vecs[e].exp_beats);
      check($sformatf("v%0d dones", e), done_cnt, vecs[e].exp_dones);
      check($sformatf("v%0d first latency", e), first_xfer_cyc - close_cyc, 2);
      check($sformatf("v%0d span", e), last_xfer_cyc - first_xfer_cyc + 1, vecs[e].exp_span);
      check($sformatf("v%0d busy_o idle", e), busy_o, 1'b0);
      check($sformatf("v%0d ld_ready_o idle", e), ld_ready_o, 1'b1);
`ifdef STREAMER_STATS_EN
      if (e == 1) check("stats after tests 2+3", beat_cnt_o, 32'd7);
`endif
      @(posedge clk_i);
      #1;
    end

    // Test 4: back-pressure with both banks full
    clear_stats();
    out_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send(beat(8'h40, i), 1'b0);
    @(negedge clk_i);
    check("t4 ld_ready_o both full", ld_ready_o, 1'b0);
    check("t4 busy_o", busy_o, 1'b1);
    repeat (4) @(negedge clk_i);
    check("t4 out_valid_o stalled", out_valid_o, 1'b1);
    check("t4 out_data_o held", out_data_o, 16'h4241);
    @(posedge clk_i);
    #1;
    ld_valid_i = 1'b1;
    ld_data_i  = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("t4 ld_ready_o stays low", ld_ready_o, 1'b0);
    end
    @(posedge clk_i);
    #1;
    ld_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int w = 0; w < 50 && !done_o; w++) @(negedge clk_i);
    check("t4 first done_o seen", done_o, 1'b1);
    check("t4 ld_ready_o at first done_o", ld_ready_o, 1'b1);
    wait_drain();
    check("t4 beats", xfer_cnt, 8);
    check("t4 dones", done_cnt, 2);
    sum_beats += 8;

`ifdef STREAMER_STATS_EN
    check("stats total", beat_cnt_o, 32'(sum_beats));
    @(posedge clk_i);
    #1;
    mon_en   = 1'b0;
    reset_ni = 1'b0;
    #1;
    check("stats reset", beat_cnt_o, 32'd0);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
`endif

    repeat (2) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
